// File: rtl/layer_stream_pkg.sv
// Shared types for the layer valid/ready streaming blocks.
package layer_stream_pkg;

  localparam int unsigned T = 9;

  typedef logic signed [T-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } strm_state_t;

endpackage

// File: rtl/lis_vec_buf.sv
// M x T register file: one synchronous write port, one asynchronous read port, async clear.
module lis_vec_buf #(
  parameter int unsigned T = 9,
  parameter int unsigned M = 5,
  localparam int unsigned AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [T-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [T-1:0]  rdata
);

  logic [T-1:0] mem [M];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < M; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_input_streamer.sv
// Streams a stored M-element vector out over valid/ready, REPS passes back to back per start.
module layer_input_streamer #(
  parameter int unsigned T  = layer_stream_pkg::T,
  parameter int unsigned M  = 5,
  parameter int unsigned RW = 8,
  localparam int unsigned AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          start,
  input  logic [RW-1:0] reps,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [T-1:0]  data_out,
  output logic          busy,
  output logic          done
);

  import layer_stream_pkg::*;

  strm_state_t   state;
  logic [AW-1:0] idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rep;
  logic [RW-1:0] reps_q;
  logic [T-1:0]  rd_data;
  logic          buf_we;
  logic          last_idx;
  logic          last_xfer;
  logic          xfer;

  assign buf_we = wr_en && !busy && ({1'b0, wr_addr} < (AW + 1)'(M));

  always_comb begin
    last_idx  = (idx == AW'(M - 1));
    nxt_idx   = last_idx ? '0 : idx + AW'(1);
    last_xfer = last_idx && (rep == reps_q - RW'(1));
    xfer      = m_valid && m_ready;
    // The read port looks one element ahead so data_out can advance on the transfer edge.
    rd_addr   = (state == SEND) ? nxt_idx : '0;
  end

  lis_vec_buf #(
    .T(T),
    .M(M)
  ) u_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (buf_we),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      rep      <= '0;
      reps_q   <= '0;
      m_valid  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (reps != '0) begin
              state    <= SEND;
              busy     <= 1'b1;
              m_valid  <= 1'b1;
              data_out <= rd_data;
              idx      <= '0;
              rep      <= '0;
              reps_q   <= reps;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_xfer) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              idx     <= '0;
              rep     <= '0;
            end else begin
              idx      <= nxt_idx;
              data_out <= rd_data;
              if (last_idx) rep <= rep + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
